// File: rtl/operand_mux_arb.sv
// rtl/operand_mux_arb.sv - N-channel operand selector with direct-select or round-robin grant
// Feeds one registered valid/ready output stage carrying the word and its source channel.
module operand_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             gvalid;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  // Round-robin search starts one past the last granted channel and wraps at CHANNELS.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    found  = 1'b0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i) begin
          grant  = SEL_W'(i);
          gvalid = in_valid[i];
        end
      end
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && in_valid[i] && (i == (int'(rr_ptr) + off) % CHANNELS)) begin
            found = 1'b1;
            grant = SEL_W'(i);
          end
        end
      end
      gvalid = found;
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && load_en && gvalid && (grant == SEL_W'(i));
      if (grant == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else begin
      if (load_en) begin
        if (xfer) begin
          out_data  <= sel_data;
          out_chan  <= grant;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (xfer && mode) rr_ptr <= grant;
    end
  end

endmodule

// File: doc/operand_mux_arb.md
Name: operand_mux_arb

Overview:
- Parametrised N-channel operand selector for the multiplier datapath; successor to the 2:1 combinational operand mux.
- Each input channel has its own valid/ready handshake. One channel is chosen per cycle, either by an explicit select or by round-robin arbitration.
- The chosen word is registered, with its channel index, into a single valid/ready output stage that feeds the multiplier operand register.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of sel and out_chan; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- mode  input  1  0 = direct select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1 (channel 0 has first priority). in_ready is all-zero while rst_n is low. Reset mid-transfer discards the held word.
- load_en = !out_valid || out_ready. The output stage loads whenever it is empty or being drained in the same cycle. This gives 1 word/cycle sustained throughput.
- Grant, mode 0:
  - grant = sel; gvalid = in_valid[sel].
  - Other channels are never granted.
  - sel >= CHANNELS gives gvalid=0 (no transfer).
- Grant, mode 1:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo CHANNELS.
  - grant = first index with in_valid set; gvalid = |in_valid.
- in_ready[i] = load_en && gvalid && (grant==i). At most one bit is set. The transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer edge: out_data <= selected word, out_chan <= grant, out_valid <= 1.
- On load_en with no transfer: out_valid <= 0. out_data and out_chan keep their last values.
- Stall (out_valid && !out_ready): out_data, out_chan and out_valid are held stable, and all in_ready are 0.
- rr_ptr updates to grant only on a transfer edge in mode 1. Mode 0 transfers leave rr_ptr unchanged.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k (visible in cycle k+1).
- Mode or sel changes apply to the grant in the same cycle, combinationally. A word already in the output register is unaffected.
- Simultaneous drain and load: the old word leaves and the new word enters on the same edge, with no bubble.
- Wrap-around: the round-robin search wraps from CHANNELS-1 to 0.
- Fairness: with all channels valid and out_ready=1, mode 1 grants 0,1,2,...,CHANNELS-1,0,...
- The output path has no combinational path from in_data to out_data. The only combinational paths are in_valid/mode/sel/out_ready to in_ready.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 and out_data=0x5A -> outputs go to 0 immediately without a clock, and in_ready=0. After release, the first round-robin grant is channel 0.
- Mode 0 select:
  - Stimulus: sel=2, in_data ch2=0xC3, all channels valid, out_ready=1.
  - Required: only in_ready[2]=1; the next cycle shows out_data=0xC3, out_chan=2, out_valid=1.
  - Then set sel=3 with in_valid[3]=0: no transfer, and out_valid drops to 0 after one cycle.
- Round-robin fairness:
  - Stimulus: mode=1, all four channels valid with data 0x10,0x20,0x30,0x40, out_ready=1 for 8 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1,2,3 and out_data 0x10..0x40 repeating.
- Sparse round-robin: only channels 1 and 3 valid, with rr_ptr=3 after the prior grant -> grants alternate 1,3,1,3. Channels 0 and 2 never see in_ready.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_data=0x77.
  - Required: out_data, out_chan and out_valid are stable and all in_ready=0.
  - Then out_ready=1 with channel 0 valid (0x88): 0x88 is loaded on the same edge the 0x77 drains, with no bubble cycle.
- Width/depth parameter sweep: WIDTH=16, CHANNELS=3, SEL_W=2, mode 1 with all valid -> grants wrap 0,1,2,0. sel=3 in mode 0 produces no transfer. Full 16-bit data 0xBEEF passes intact.
